// File: rtl/oper_sel_stage.sv
// oper_sel_stage: registered operand-A selection stage.
// Picks one of NUM_SRC candidate operands per transaction. The result is
// delivered through a two-entry valid/ready skid buffer, which gives one
// cycle of latency and full throughput.
// Optional feature macro: OPER_SEL_ERR_EN. When it is defined, sel_err is a
// sticky flag for out-of-range selects. When it is undefined, sel_err is
// tied to 0.
// NUM_SRC must be in 2..16, and 2**SEL_W must be >= NUM_SRC.
module oper_sel_stage #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    // Unpacked view of the flattened source bus.
    logic [WIDTH-1:0] src_arr [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_arr[gi] = src_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Main register drives the outputs; the skid register catches the
    // beat that arrives while main is stalled.
    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic [SEL_W-1:0] main_sel_q,   main_sel_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [SEL_W-1:0] skid_sel_q,   skid_sel_d;

    logic [WIDTH-1:0] sel_data;
    logic             sel_in_range;
    logic             in_fire;
    logic             out_fire;

    // Source mux. A select that matches no source yields zero data.
    always_comb begin
        sel_data     = '0;
        sel_in_range = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_data     = src_arr[i];
                sel_in_range = 1'b1;
            end
        end
    end

    // in_ready comes only from registered state, so there is no
    // combinational path from out_ready. It is held low during reset.
    assign in_ready  = !skid_valid_q && !rst;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid_q && out_ready;

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;

    // Buffer next-state logic. Flush wins over every transfer. The skid
    // register can only be full while main is full, so a skid-to-main move
    // never competes with a new input beat (in_ready is low then).
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_sel_d   = main_sel_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_sel_d   = skid_sel_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = sel_data;
                main_sel_d   = sel;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = sel_data;
            skid_sel_d   = sel;
        end
    end

    // Buffer registers. Reset clears everything so the outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_sel_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_sel_q   <= main_sel_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
        end
    end

`ifdef OPER_SEL_ERR_EN
    logic sel_err_q, sel_err_d;

    // Sticky error: set by any accepted out-of-range select. Only reset
    // clears it; flush leaves it alone.
    always_comb begin
        sel_err_d = sel_err_q | (in_fire & ~sel_in_range);
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    // Range flag only feeds the error register; fold it away here.
    logic unused_range;
    assign unused_range = sel_in_range;
    assign sel_err      = 1'b0;
`endif

endmodule

// File: tb/tb_oper_sel_stage.sv
// Bench for oper_sel_stage. A queue model of the two-entry buffer predicts
// in_ready, out_valid and the head payload on every cycle. A second instance
// covers the NUM_SRC=4 / WIDTH=8 build.
module tb_oper_sel_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [95:0] src_data;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;

    logic [31:0] src4;
    logic [1:0]  sel4;
    logic        iv4;
    logic        ir4;
    logic [7:0]  od4;
    logic [1:0]  os4;
    logic        ov4;
    logic        or4;
    logic        se4;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  s;
    } beat_t;
    beat_t sbq[$];

    typedef struct {
        logic [1:0]  s;
        logic [31:0] exp_data;
    } vec_t;
    vec_t tv[4];

    logic exp_err;

    always #5 clk = ~clk;

    oper_sel_stage #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .src_data(src_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    oper_sel_stage #(.WIDTH(8), .NUM_SRC(4), .SEL_W(2)) u_dut4 (
        .clk(clk), .rst(rst), .flush(1'b0), .src_data(src4), .sel(sel4),
        .in_valid(iv4), .in_ready(ir4), .out_data(od4),
        .out_sel(os4), .out_valid(ov4), .out_ready(or4),
        .sel_err(se4)
    );

    function automatic logic [31:0] ref_sel(input logic [1:0] s);
        case (s)
            2'd0:    return 32'd1807;
            2'd1:    return 32'd2703;
            2'd2:    return 32'd707;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the negedge, compare 1 ns later against the
    // model, then update the model and wait for the following negedge.
    task automatic cycle(input logic iv, input logic [1:0] s, input logic [31:0] e,
                         input logic ordy, input logic fl);
        int  occ;
        logic mrdy;
        in_valid  = iv;
        sel       = s;
        out_ready = ordy;
        flush     = fl;
        occ  = sbq.size();
        mrdy = (occ < 2) && !rst;
        #1;
        check("in_ready", in_ready, mrdy);
        if (!rst) begin
            check("out_valid", out_valid, occ != 0);
            if (occ != 0) begin
                check("out_data", out_data, sbq[0].data);
                check("out_sel", out_sel, sbq[0].s);
                if (ordy) void'(sbq.pop_front());
            end
            if (iv && mrdy) sbq.push_back('{data: e, s: s});
        end
        $display("cyc t=%0t iv=%0b sel=%0d ordy=%0b fl=%0b rst=%0b | ir=%0b ov=%0b od=%0d os=%0d err=%0b",
                 $time, iv, s, ordy, fl, rst, in_ready, out_valid, out_data, out_sel, sel_err);
        @(negedge clk);
        if (rst || fl) sbq.delete();
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && sbq.size() != 0; k++) cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        check("drain_empty", sbq.size(), 0);
    endtask

    initial begin
`ifdef OPER_SEL_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; sel = 2'd0; out_ready = 1'b0;
        src_data = {32'd707, 32'd2703, 32'd1807};
        src4 = 32'hA5332211; sel4 = 2'd0; iv4 = 1'b0; or4 = 1'b1;
        tv[0] = '{s: 2'd0, exp_data: 32'd1807};
        tv[1] = '{s: 2'd1, exp_data: 32'd2703};
        tv[2] = '{s: 2'd2, exp_data: 32'd707};
        tv[3] = '{s: 2'd3, exp_data: 32'd0};
        @(negedge clk);

        // Reset state
        cycle(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sel", out_sel, 0);
        check("rst_sel_err", sel_err, 0);
        rst = 1'b0;
        cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);

        // Back-to-back selects 0..3
        for (int i = 0; i < 4; i++) cycle(1'b1, tv[i].s, tv[i].exp_data, 1'b1, 1'b0);
        drain();
        check("sel_err_after_oob", sel_err, exp_err);

        // Backpressure: one beat in main, one in skid, then release
        cycle(1'b1, 2'd1, ref_sel(2'd1), 1'b0, 1'b0);
        cycle(1'b1, 2'd2, ref_sel(2'd2), 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        cycle(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        drain();
        cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);

        // Continuous input, out_ready toggling every cycle
        for (int k = 0; k < 40; k++) begin
            logic [1:0] s;
            s = 2'($urandom_range(0, 3));
            cycle(1'b1, s, ref_sel(s), (k % 2) == 0, 1'b0);
        end
        drain();

        // Flush with two beats buffered and a beat offered
        cycle(1'b1, 2'd0, ref_sel(2'd0), 1'b0, 1'b0);
        cycle(1'b1, 2'd1, ref_sel(2'd1), 1'b0, 1'b0);
        cycle(1'b1, 2'd2, ref_sel(2'd2), 1'b0, 1'b1);
        cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        // Flush that coincides with an accepted input transfer
        cycle(1'b1, 2'd0, ref_sel(2'd0), 1'b0, 1'b0);
        cycle(1'b1, 2'd1, ref_sel(2'd1), 1'b0, 1'b1);
        cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        check("sel_err_after_flush", sel_err, exp_err);

        // Reset with main and skid both full
        cycle(1'b1, 2'd1, ref_sel(2'd1), 1'b0, 1'b0);
        cycle(1'b1, 2'd2, ref_sel(2'd2), 1'b0, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_sel_err", sel_err, 0);
        rst = 1'b0;
        cycle(1'b0, 2'd0, 32'd0, 1'b1, 1'b0);
        cycle(1'b1, 2'd2, ref_sel(2'd2), 1'b1, 1'b0);
        drain();

        // Four-source, 8-bit build: the top source is reachable
        sel4 = 2'd3; iv4 = 1'b1;
        #1;
        check("w8_in_ready", ir4, 1);
        @(negedge clk);
        iv4 = 1'b0;
        #1;
        check("w8_out_valid", ov4, 1);
        check("w8_out_data", od4, 8'hA5);
        check("w8_out_sel", os4, 3);
        check("w8_sel_err", se4, 0);
        $display("w8 t=%0t sel=3 od=%0h err=%0b", $time, od4, se4);
        @(negedge clk);
        check("w8_drained", ov4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oper_sel_stage.md
# oper_sel_stage

Parametrised, registered operand-A selection stage for the Proyecto4 datapath. It takes NUM_SRC candidate operands of WIDTH bits, selects one per transaction, and delivers it through a valid/ready skid buffer. The stage gives full throughput and one cycle of latency. It sits between operand sourcing (register file read, extended immediate, shifted immediate) and the ALU operand-A input.

## Interface
- WIDTH, 32, operand width in bits
- NUM_SRC, 3, number of candidate sources (2..16)
- SEL_W, 2, select width; 2**SEL_W >= NUM_SRC is required
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all buffered transactions
- src_data  in  NUM_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH]
- sel  in  SEL_W  source index, sampled with in_valid
- in_valid  in  1  upstream transaction present
- in_ready  out  1  stage can accept
- out_data  out  WIDTH  selected operand
- out_sel  out  SEL_W  select value that produced out_data
- out_valid  out  1  out_data/out_sel valid
- out_ready  in  1  downstream accepts
- sel_err  out  1  sticky out-of-range select flag (see Configuration)

## Operation
- Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
- Storage: main register (drives outputs) plus one skid register.
- Accept into main when main is empty or is draining this cycle. Otherwise accept into skid.
- When main drains and skid is full, skid moves to main in the same cycle.
- in_ready = !skid_valid, registered-derived with no combinational path from out_ready. in_ready is forced 0 while rst = 1.
- Selection: out_data = source[sel] when sel < NUM_SRC. Otherwise out_data = 0, and the transaction still completes normally.
- Payload is frozen while out_valid && !out_ready; no field of out_data/out_sel changes until the transfer.
- flush = 1: main_valid and skid_valid clear at the next edge. A simultaneous input transfer is discarded. Data registers need not clear. flush has priority over all transfers; rst has priority over flush.

## Timing
- Reset values: out_valid 0, out_data 0, out_sel 0, sel_err 0, skid empty. in_ready is 1 the cycle after rst deasserts.
- Latency: accepted at edge N, visible on out_* after edge N (same cycle as N+1 combinationally); one cycle.
- Throughput: one transaction per cycle with out_ready held high.
- Backpressure: first stalled beat lands in skid. in_ready drops the cycle after the skid fills. It rises the cycle after the skid empties.
- Simultaneous in and out transfer with skid empty: main reloads with the new beat and out_valid stays 1.
- Reset mid-operation: all buffered beats are lost and no partial output is produced.
- Ordering: strictly FIFO and never reorders; maximum occupancy is 2.

## Configuration
- Macro OPER_SEL_ERR_EN.
- Defined: sel_err sets at the edge that accepts a beat with sel >= NUM_SRC. It holds until rst; flush does not clear it.
- Undefined: sel_err is tied to 0 and no error register is built. Out-of-range selects still yield 0 data.

## Test plan
- Reset, then sources {1807, 2703, 707}, sel 0,1,2,3 back-to-back with out_ready=1 -> out_data 1807, 2703, 707, 0 on consecutive cycles. out_sel follows 0..3. sel_err=1 after the 4th accept if OPER_SEL_ERR_EN, else 0.
- Hold out_ready=0, send sel=1 then sel=2 -> in_ready falls after the second accept, out_data stays 2703. Release out_ready -> 2703 then 707, in_ready returns to 1.
- Continuous in_valid with out_ready toggling 1/0 every cycle -> no beat lost or duplicated, order preserved, and the output payload is stable while stalled.
- Two beats buffered, assert flush for one cycle together with in_valid -> out_valid=0 next cycle. The concurrent beat is discarded and in_ready=1.
- Assert rst with out_valid=1 and skid full -> next cycle out_valid=0, out_data=0, and in_ready=0 during rst, 1 after.
- NUM_SRC=4, WIDTH=8 build, sel=3 with source3=0xA5 -> out_data=0xA5 and sel_err stays 0.
